// File: rtl/rename_pkg.sv
// Shared rename-stage parameters and types.
// Physical register ids, architectural ids, reserved zero register.
package rename_pkg;

  localparam int NR_PHYS_REGS   = 64;
  localparam int NR_ARCH_REGS   = 32;
  localparam int PHYS_REG_WIDTH = $clog2(NR_PHYS_REGS);
  localparam int ARCH_REG_WIDTH = $clog2(NR_ARCH_REGS);

  typedef logic [PHYS_REG_WIDTH-1:0] preg_t;

  localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/preg_prio_enc.sv
// Lowest-set-bit priority encoder.
// Reports index 0 and valid 0 when no bit is set.
module preg_prio_enc #(
  parameter int N = 64,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Scan downward so the lowest set bit is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx   = W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Bitmap free list of physical registers.
// Offers the lowest free register; reclaims registers on commit.
module phys_reg_free_list
  import rename_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_i,
  output logic                  alloc_valid_o,
  output preg_t                 alloc_preg_o,
  input  logic                  free_i,
  input  preg_t                 free_preg_i,
  output logic [PHYS_REG_WIDTH:0] free_cnt_o,
  output logic                  err_o
);

  localparam logic [NR_PHYS_REGS-1:0] FREE_RST =
    {{(NR_PHYS_REGS-1){1'b1}}, 1'b0};

  logic [NR_PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_REG_WIDTH:0] cnt_q, cnt_d;
  logic                    err_q;

  logic do_alloc, bad_alloc;
  logic do_free, bad_free;
  logic out_of_range;

  preg_prio_enc #(
    .N (NR_PHYS_REGS),
    .W (PHYS_REG_WIDTH)
  ) u_enc (
    .bits  (free_q),
    .idx   (alloc_preg_o),
    .valid (alloc_valid_o)
  );

  assign out_of_range =
    int'(free_preg_i) >= NR_PHYS_REGS;

  assign do_alloc  = alloc_i & alloc_valid_o;
  assign bad_alloc = alloc_i & ~alloc_valid_o;

  // Freeing the offered register is a double free, so alloc wins.
  assign bad_free = free_i &
    ((free_preg_i == PREG_ZERO) |
     out_of_range |
     free_q[free_preg_i]);
  assign do_free = free_i & ~bad_free;

  always_comb begin
    free_d = free_q;
    if (do_alloc)
      free_d[alloc_preg_o] = 1'b0;
    if (do_free)
      free_d[free_preg_i] = 1'b1;
  end

  assign cnt_d = cnt_q
    + (PHYS_REG_WIDTH+1)'(do_free)
    - (PHYS_REG_WIDTH+1)'(do_alloc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_q <= FREE_RST;
      cnt_q  <= (PHYS_REG_WIDTH+1)'(NR_PHYS_REGS-1);
      err_q  <= 1'b0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
      err_q  <= bad_alloc | bad_free;
    end
  end

  assign free_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule
